// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: synchronizes and edge-detects interrupt lines, keeps masked pending
// requests and hands one source at a time to the OTTER multicycle control unit.
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       IC_CLK,
  input  logic                       IC_RESET,
  input  logic [NUM_SRC-1:0]         IC_SRC,
  input  logic                       IC_MIE,
  input  logic                       IC_CSR_WE,
  input  logic [NUM_SRC-1:0]         IC_CSR_WDATA,
  input  logic                       IC_intCLR,
  input  logic                       IC_intTaken,
  output logic                       IC_INT,
  output logic                       IC_prevINT,
  output logic [$clog2(NUM_SRC)-1:0] IC_CAUSE,
  output logic                       IC_ACTIVE,
  output logic [NUM_SRC-1:0]         IC_EN,
  output logic [NUM_SRC-1:0]         IC_PENDING
);

  localparam int CW = $clog2(NUM_SRC);

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0]                  prev_q, prev_d;
  logic [NUM_SRC-1:0]                  pending_q, pending_d;
  logic [NUM_SRC-1:0]                  en_q, en_d;
  logic                                active_q, active_d;
  logic [CW-1:0]                       cause_q, cause_d;

  logic [NUM_SRC-1:0] rise_s, eligible_s, cap_mask_s;
  logic [CW-1:0]      sel_idx_s;
  logic               int_s, prev_int_s, capture_s;

  // Request detection and the capture condition seen by the control unit.
  always_comb begin
    rise_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
    eligible_s = (pending_q | rise_s) & en_q;
    int_s      = IC_MIE & ~active_q & (|(rise_s & en_q));
    prev_int_s = IC_MIE & ~active_q & (|(pending_q & en_q));
    capture_s  = IC_intCLR & ~IC_intTaken & ~active_q & (int_s | prev_int_s);
  end

  // Fixed priority: the lowest-index eligible source wins, so scan from the top down.
  always_comb begin
    sel_idx_s = {CW{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        sel_idx_s = CW'(i);
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
  end

  // Next-state logic; the captured source's pending bit and same-cycle rise are consumed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], IC_SRC};
    prev_d = sync_q[SYNC_STAGES-1];
    en_d   = IC_CSR_WE ? IC_CSR_WDATA : en_q;
    if (capture_s) begin
      cap_mask_s = {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_idx_s;
      cause_d    = sel_idx_s;
    end else begin
      cap_mask_s = {NUM_SRC{1'b0}};
      cause_d    = cause_q;
    end
    pending_d = (pending_q | (rise_s & en_q)) & ~cap_mask_s;
    if (IC_intTaken) begin
      active_d = 1'b0;
    end else if (capture_s) begin
      active_d = 1'b1;
    end else begin
      active_d = active_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge IC_CLK) begin
    if (IC_RESET) begin
      sync_q    <= {(SYNC_STAGES*NUM_SRC){1'b0}};
      prev_q    <= {NUM_SRC{1'b0}};
      pending_q <= {NUM_SRC{1'b0}};
      en_q      <= {NUM_SRC{1'b0}};
      active_q  <= 1'b0;
      cause_q   <= {CW{1'b0}};
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      en_q      <= en_d;
      active_q  <= active_d;
      cause_q   <= cause_d;
    end
  end

  assign IC_INT     = int_s;
  assign IC_prevINT = prev_int_s;
  assign IC_CAUSE   = cause_q;
  assign IC_ACTIVE  = active_q;
  assign IC_EN      = en_q;
  assign IC_PENDING = pending_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: directed scenarios followed by a random phase, all
// compared against a cycle-level behavioural model of the controller.
module tb_otter_intr_ctrl;
  localparam int NS = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mie, we, clr, taken;
  logic [NS-1:0] src, wdata;
  logic          int_o, prev_o, active_o;
  logic [1:0]    cause_o;
  logic [NS-1:0] en_o, pend_o;

  otter_intr_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
    .IC_CLK(clk), .IC_RESET(rst), .IC_SRC(src), .IC_MIE(mie),
    .IC_CSR_WE(we), .IC_CSR_WDATA(wdata), .IC_intCLR(clr), .IC_intTaken(taken),
    .IC_INT(int_o), .IC_prevINT(prev_o), .IC_CAUSE(cause_o), .IC_ACTIVE(active_o),
    .IC_EN(en_o), .IC_PENDING(pend_o)
  );

  int total = 0;
  int bad   = 0;

  // Model: samp[k] is the IC_SRC value sampled k+1 edges ago (zero right after reset).
  logic [NS-1:0] samp [0:SS];
  logic [NS-1:0] m_pend, m_en;
  logic          m_act;
  int            m_cause;

  function automatic logic [NS-1:0] m_rise();
    return samp[SS-1] & ~samp[SS];
  endfunction

  function automatic logic m_int();
    return mie && !m_act && ((m_rise() & m_en) != '0);
  endfunction

  function automatic logic m_prev();
    return mie && !m_act && ((m_pend & m_en) != '0);
  endfunction

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag);
    chk_v({tag, "_int"},    32'(int_o),    32'(m_int()));
    chk_v({tag, "_prev"},   32'(prev_o),   32'(m_prev()));
    chk_v({tag, "_cause"},  32'(cause_o),  32'(m_cause));
    chk_v({tag, "_active"}, 32'(active_o), 32'(m_act));
    chk_v({tag, "_en"},     32'(en_o),     32'(m_en));
    chk_v({tag, "_pend"},   32'(pend_o),   32'(m_pend));
  endtask

  task automatic tick();
    logic [NS-1:0] r, elig, np;
    logic          cap;
    int            sel;
    r    = m_rise();
    elig = (m_pend | r) & m_en;
    cap  = clr && !taken && !m_act && (m_int() || m_prev());
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k <= SS; k++) samp[k] = '0;
      m_pend = '0; m_en = '0; m_act = 1'b0; m_cause = 0;
    end else begin
      sel = -1;
      for (int i = 0; i < NS; i++) if (elig[i] && sel < 0) sel = i;
      np = m_pend | (r & m_en);
      if (cap) begin
        np[sel] = 1'b0;
        m_cause = sel;
        m_act   = 1'b1;
      end
      if (taken) m_act = 1'b0;
      if (we) m_en = wdata;
      m_pend = np;
      for (int k = SS; k > 0; k--) samp[k] = samp[k-1];
      samp[0] = src;
    end
    #1;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag);
    end
  endtask

  initial begin
    for (int k = 0; k <= SS; k++) samp[k] = '0;
    m_pend = '0; m_en = '0; m_act = 1'b0; m_cause = 0;
    rst = 1'b1; src = '0; mie = 1'b0; we = 1'b0; wdata = '0; clr = 1'b0; taken = 1'b0;
    tick(); tick();
    chk("reset");
    chk_v("reset_pend_c", 32'(pend_o), 32'h0);
    rst = 1'b0;

    // Single pulse on source 0 with only source 0 enabled.
    mie = 1'b1; we = 1'b1; wdata = 4'b0001;
    tick(); we = 1'b0; chk("en_wr");
    src = 4'b0001;
    tick(); chk("p_e1");
    chk_v("p_e1_int_c", 32'(int_o), 32'h0);
    tick(); chk("p_e2");
    chk_v("p_e2_int_c", 32'(int_o), 32'h1);
    tick(); chk("p_e3");
    chk_v("p_e3_int_c", 32'(int_o), 32'h0);
    chk_v("p_e3_pend_c", 32'(pend_o), 32'h1);
    chk_v("p_e3_prev_c", 32'(prev_o), 32'h1);
    src = 4'b0000;
    ticks(3, "p_hold");
    clr = 1'b1; tick(); clr = 1'b0; chk("p_cap");
    taken = 1'b1; tick(); taken = 1'b0; chk("p_take");

    // Disabled source 2 is dropped.
    src = 4'b0100;
    ticks(4, "dis");
    chk_v("dis_pend_c", 32'(pend_o), 32'h0);
    chk_v("dis_prev_c", 32'(prev_o), 32'h0);
    src = 4'b0000;
    ticks(3, "dis_lo");

    // Sources 1 and 3 together, serviced in priority order.
    we = 1'b1; wdata = 4'b1111; tick(); we = 1'b0; chk("en_all");
    src = 4'b1010;
    ticks(3, "pair");
    clr = 1'b1; tick(); clr = 1'b0; chk("pair_cap1");
    chk_v("cap1_cause_c", 32'(cause_o), 32'h1);
    chk_v("cap1_pend_c", 32'(pend_o), 32'h8);
    chk_v("cap1_act_c", 32'(active_o), 32'h1);
    chk_v("cap1_prev_c", 32'(prev_o), 32'h0);
    taken = 1'b1; tick(); taken = 1'b0; chk("pair_take1");
    chk_v("take1_act_c", 32'(active_o), 32'h0);
    chk_v("take1_prev_c", 32'(prev_o), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0; chk("pair_cap2");
    chk_v("cap2_cause_c", 32'(cause_o), 32'h3);
    chk_v("cap2_pend_c", 32'(pend_o), 32'h0);
    taken = 1'b1; tick(); taken = 1'b0; chk("pair_take2");
    src = 4'b0000;
    ticks(3, "pair_lo");

    // Global enable gating.
    mie = 1'b0; src = 4'b0001;
    ticks(3, "mie0");
    chk_v("mie0_pend_c", 32'(pend_o), 32'h1);
    chk_v("mie0_prev_c", 32'(prev_o), 32'h0);
    mie = 1'b1; #1; chk("mie1");
    chk_v("mie1_prev_c", 32'(prev_o), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0; chk("mie_cap");

    // intCLR together with intTaken while active: no capture.
    src = 4'b0101;
    ticks(3, "both_pre");
    clr = 1'b1; taken = 1'b1; tick(); clr = 1'b0; taken = 1'b0; chk("both");
    chk_v("both_cause_c", 32'(cause_o), 32'h0);
    chk_v("both_act_c", 32'(active_o), 32'h0);
    chk_v("both_prev_c", 32'(prev_o), 32'h1);

    // Reset in service with two pending, then one fresh rise per held source.
    clr = 1'b1; tick(); clr = 1'b0; chk("rs_cap");
    src = 4'b0000; ticks(3, "rs_lo");
    src = 4'b0110; ticks(3, "rs_hi");
    chk_v("rs_pend_c", 32'(pend_o), 32'h6);
    chk_v("rs_act_c", 32'(active_o), 32'h1);
    rst = 1'b1; tick(); chk("rs_rst");
    chk_v("rs_rst_act_c", 32'(active_o), 32'h0);
    chk_v("rs_rst_pend_c", 32'(pend_o), 32'h0);
    rst = 1'b0; we = 1'b1; wdata = 4'b1111;
    tick(); we = 1'b0; chk("rs_e1");
    tick(); chk("rs_e2");
    chk_v("rs_e2_int_c", 32'(int_o), 32'h1);
    ticks(3, "rs_after");
    chk_v("rs_after_pend_c", 32'(pend_o), 32'h6);

    // Random phase against the model.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      mie   = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 2) == 0);
      taken = ($urandom_range(0, 3) == 0);
      we    = ($urandom_range(0, 15) == 0);
      wdata = 4'($urandom);
      if ($urandom_range(0, 2) == 0) src = src ^ (4'b0001 << $urandom_range(0, 3));
      tick();
      chk("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
